// File: rtl/ws2811_frame_ctrl.sv
// ws2811_frame_ctrl
// Frame sequencer for one ws2811 satellite: assembles MSB-first bytes from the
// decoder's bit stream, claims the first NUM_BYTES bytes of each frame, raises
// fwdEn for the downstream bytes, and commits the claimed bytes atomically at
// frame end. Short frames and commits blocked by an unacknowledged frame are
// counted in a saturating error counter.
module ws2811_frame_ctrl #(
   parameter int unsigned NUM_BYTES  = 3,
   parameter int unsigned SKIP_FIRST = 1,
   parameter int unsigned ERRCNT_W   = 8
) (
   input  logic                   masterClk,
   input  logic                   nReset,
   input  logic                   bitData,
   input  logic                   bitClk,
   input  logic                   active,
   input  logic                   frameAck,
   output logic [8*NUM_BYTES-1:0] frameData,
   output logic                   frameValid,
   output logic                   fwdEn,
   output logic                   busy,
   output logic [ERRCNT_W-1:0]    errCnt
);

   localparam int unsigned BCW = $clog2(NUM_BYTES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RECV,
      S_FWD,
      S_COMMIT
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;

   logic                   r_bitClkPrev;
   logic                   r_activePrev;
   // Holds the 7 most recent bits; the 8th bit of a byte is taken straight
   // from bitData on the completing bit event.
   logic [6:0]             r_shift;
   logic [2:0]             r_bitCnt;
   logic [BCW-1:0]         r_byteCnt;
   logic [7:0]             r_stage [NUM_BYTES];
   logic [8*NUM_BYTES-1:0] r_frameData;
   logic                   r_frameValid;
   logic                   r_fwdEn;
   logic [ERRCNT_W-1:0]    r_errCnt;

   logic                   w_bitRise;
   logic                   w_actRise;
   logic                   w_frameEnd;
   logic                   w_lastBit;
   logic                   w_lastByte;
   logic [7:0]             w_byte;
   logic [8*NUM_BYTES-1:0] w_stagePacked;
   logic                   w_clrCnt;
   logic                   w_shiftEn;
   logic                   w_fwdSet;
   logic                   w_fwdClr;
   logic                   w_errInc;
   logic                   w_commit;

   assign w_bitRise  = bitClk & ~r_bitClkPrev;
   assign w_actRise  = active & ~r_activePrev;
   assign w_frameEnd = ~active & r_activePrev;
   assign w_lastBit  = (r_bitCnt == 3'd7);
   assign w_lastByte = (r_byteCnt == BCW'(NUM_BYTES - 1));
   assign w_byte     = {r_shift, bitData};

   assign frameData  = r_frameData;
   assign frameValid = r_frameValid;
   assign fwdEn      = r_fwdEn;
   assign errCnt     = r_errCnt;
   assign busy       = (r_state != S_IDLE);

   // Pack staging slots with slot 0 in the most significant byte.
   always_comb begin
      w_stagePacked = '0;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         w_stagePacked[8*(NUM_BYTES-1-i) +: 8] = r_stage[i];
      end
   end

   // FSM state register.
   always_ff @(posedge masterClk) begin
      if (!nReset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and control decode; a bit event in the same cycle as a frame
   // end is applied first, so a frame whose last claimed bit coincides with the
   // end of active still commits.
   always_comb begin
      w_nextState = r_state;
      w_clrCnt    = 1'b0;
      w_shiftEn   = 1'b0;
      w_fwdSet    = 1'b0;
      w_fwdClr    = 1'b0;
      w_errInc    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clrCnt = 1'b1;
            if (w_actRise) begin
               w_nextState = (SKIP_FIRST != 0) ? S_ARM : S_RECV;
            end
         end
         S_ARM: begin
            if (w_frameEnd) begin
               w_nextState = S_IDLE;
            end else if (w_bitRise) begin
               w_nextState = S_RECV;
            end
         end
         S_RECV: begin
            if (w_bitRise) begin
               w_shiftEn = 1'b1;
            end
            if (w_bitRise && w_lastBit && w_lastByte) begin
               if (w_frameEnd) begin
                  w_nextState = S_COMMIT;
               end else begin
                  w_nextState = S_FWD;
                  w_fwdSet    = 1'b1;
               end
            end else if (w_frameEnd) begin
               w_errInc    = 1'b1;
               w_nextState = S_IDLE;
            end
         end
         S_FWD: begin
            if (w_frameEnd) begin
               w_fwdClr    = 1'b1;
               w_nextState = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_nextState = S_IDLE;
            if (!r_frameValid || frameAck) begin
               w_commit = 1'b1;
            end else begin
               w_errInc = 1'b1;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Input edge history, byte assembly and staging writes.
   always_ff @(posedge masterClk) begin
      if (!nReset) begin
         r_bitClkPrev <= 1'b0;
         r_activePrev <= 1'b0;
         r_shift      <= '0;
         r_bitCnt     <= '0;
         r_byteCnt    <= '0;
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_bitClkPrev <= bitClk;
         r_activePrev <= active;
         if (w_clrCnt) begin
            r_bitCnt  <= '0;
            r_byteCnt <= '0;
         end else if (w_shiftEn) begin
            r_shift  <= {r_shift[5:0], bitData};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (w_lastBit) begin
               for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                  if (r_byteCnt == BCW'(i)) begin
                     r_stage[i] <= w_byte;
                  end
               end
               r_byteCnt <= r_byteCnt + BCW'(1);
            end
         end
      end
   end

   // Output register, valid flag, forward enable and saturating error count.
   always_ff @(posedge masterClk) begin
      if (!nReset) begin
         r_frameData  <= '0;
         r_frameValid <= 1'b0;
         r_fwdEn      <= 1'b0;
         r_errCnt     <= '0;
      end else begin
         if (w_commit) begin
            r_frameData  <= w_stagePacked;
            r_frameValid <= 1'b1;
         end else if (frameAck) begin
            r_frameValid <= 1'b0;
         end
         if (w_fwdSet) begin
            r_fwdEn <= 1'b1;
         end else if (w_fwdClr) begin
            r_fwdEn <= 1'b0;
         end
         if (w_errInc && (r_errCnt != '1)) begin
            r_errCnt <= r_errCnt + ERRCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
// Bench for ws2811_frame_ctrl (NUM_BYTES=3, SKIP_FIRST=1, ERRCNT_W=8).
// Frames are built as bit queues; a frame-level reference model predicts the
// committed data, valid flag and error count from the frame length and ack.
module tb_ws2811_frame_ctrl;

   localparam int NB = 3;
   localparam int DW = 8 * NB;

   logic          masterClk = 1'b0;
   logic          nReset    = 1'b0;
   logic          bitData   = 1'b0;
   logic          bitClk    = 1'b0;
   logic          active    = 1'b0;
   logic          frameAck  = 1'b0;
   logic [DW-1:0] frameData;
   logic          frameValid;
   logic          fwdEn;
   logic          busy;
   logic [7:0]    errCnt;

   ws2811_frame_ctrl #(
      .NUM_BYTES (NB),
      .SKIP_FIRST(1),
      .ERRCNT_W  (8)
   ) dut (
      .masterClk (masterClk),
      .nReset    (nReset),
      .bitData   (bitData),
      .bitClk    (bitClk),
      .active    (active),
      .frameAck  (frameAck),
      .frameData (frameData),
      .frameValid(frameValid),
      .fwdEn     (fwdEn),
      .busy      (busy),
      .errCnt    (errCnt)
   );

   always #5 masterClk = ~masterClk;

   int total = 0;
   int bad   = 0;

   bit          q_bits[$];
   logic [63:0] obs_fwd;
   logic        obs_fwd_end;
   logic        obs_busy_c;

   // Reference model state.
   logic [DW-1:0] m_data  = '0;
   logic          m_valid = 1'b0;
   int            m_err   = 0;

   function automatic void model_frame(input bit ack);
      if (q_bits.size() < DW) begin
         if (m_err < 255) m_err++;
         if (ack) m_valid = 1'b0;
      end else if (!m_valid || ack) begin
         for (int i = 0; i < DW; i++) m_data[DW-1-i] = q_bits[i];
         m_valid = 1'b1;
      end else begin
         if (m_err < 255) m_err++;
      end
   endfunction

   function automatic logic [63:0] exp_fwd_vec();
      logic [63:0] v = '0;
      if (q_bits.size() >= DW) begin
         for (int i = DW - 1; i < q_bits.size() && i < 64; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) q_bits.push_back(b[i]);
   endtask

   task automatic send_bit(input bit b, input int idx);
      @(negedge masterClk); bitData = b; bitClk = 1'b1;
      @(negedge masterClk);
      if (idx >= 0 && idx < 64) obs_fwd[idx] = fwdEn;
      @(negedge masterClk); bitClk = 1'b0;
      @(negedge masterClk);
   endtask

   task automatic run_frame(input bit stale, input bit ack);
      obs_fwd = '0;
      @(negedge masterClk); active = 1'b1;
      repeat (2) @(negedge masterClk);
      send_bit(stale, -1);
      foreach (q_bits[i]) send_bit(q_bits[i], i);
      @(negedge masterClk); active = 1'b0;
      @(negedge masterClk);
      obs_fwd_end = fwdEn;
      obs_busy_c  = busy;
      frameAck    = ack;
      @(negedge masterClk); frameAck = 1'b0;
   endtask

   task automatic test_reset_initial();
      repeat (3) @(negedge masterClk);
      total++;
      if ({frameData, frameValid, fwdEn, busy, errCnt} !== '0) begin
         bad++;
         $display("FAIL reset_initial: got data=%h v=%b f=%b b=%b e=%0d required all 0",
                  frameData, frameValid, fwdEn, busy, errCnt);
      end
      nReset = 1'b1;
      @(negedge masterClk);
   endtask

   task automatic test_basic();
      q_bits.delete();
      push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hF0);
      push_byte(8'h12); push_byte(8'h34);
      run_frame(1'b0, 1'b0);
      model_frame(1'b0);
      total++;
      if (obs_fwd !== exp_fwd_vec()) begin
         bad++; $display("FAIL basic_fwd: got %h required %h", obs_fwd, exp_fwd_vec());
      end
      total++;
      if (obs_fwd_end !== 1'b0 || obs_busy_c !== 1'b1) begin
         bad++; $display("FAIL basic_commit_cycle: got fwd=%b busy=%b required fwd=0 busy=1",
                         obs_fwd_end, obs_busy_c);
      end
      total++;
      if (frameData !== 24'hA53CF0 || frameValid !== 1'b1) begin
         bad++; $display("FAIL basic_data: got %h v=%b required a53cf0 v=1", frameData, frameValid);
      end
      total++;
      if (busy !== 1'b0 || errCnt !== 8'd0) begin
         bad++; $display("FAIL basic_idle: got busy=%b err=%0d required 0 0", busy, errCnt);
      end
   endtask

   task automatic test_ack_clear();
      @(negedge masterClk); frameAck = 1'b1;
      @(negedge masterClk); frameAck = 1'b0;
      m_valid = 1'b0;
      total++;
      if (frameValid !== 1'b0 || frameData !== m_data) begin
         bad++; $display("FAIL ack_clear: got v=%b data=%h required v=0 data=%h",
                         frameValid, frameData, m_data);
      end
   endtask

   task automatic test_short();
      q_bits.delete();
      push_byte(8'h11); push_byte(8'h22);
      for (int i = 0; i < 5; i++) q_bits.push_back(1'b1);
      run_frame(1'b1, 1'b0);
      model_frame(1'b0);
      total++;
      if (errCnt !== 8'(m_err) || frameValid !== m_valid || frameData !== m_data) begin
         bad++; $display("FAIL short: got err=%0d v=%b data=%h required err=%0d v=%b data=%h",
                         errCnt, frameValid, frameData, m_err, m_valid, m_data);
      end
      total++;
      if (obs_busy_c !== 1'b0 || obs_fwd !== 64'd0) begin
         bad++; $display("FAIL short_ctl: got busy=%b fwd=%h required busy=0 fwd=0",
                         obs_busy_c, obs_fwd);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] f1;
      for (int k = 0; k < 3; k++) begin
         q_bits.delete();
         for (int j = 0; j < NB; j++) push_byte(8'($urandom));
         if (k == 0) for (int i = 0; i < DW; i++) f1[DW-1-i] = q_bits[i];
         run_frame(1'($urandom), k == 2);
         model_frame(k == 2);
         total++;
         if (frameData !== m_data || frameValid !== m_valid || errCnt !== 8'(m_err)) begin
            bad++; $display("FAIL back_to_back[%0d]: got data=%h v=%b err=%0d required data=%h v=%b err=%0d",
                            k, frameData, frameValid, errCnt, m_data, m_valid, m_err);
         end
         if (k == 1) begin
            total++;
            if (frameData !== f1) begin
               bad++; $display("FAIL drop_keeps_old: got %h required %h", frameData, f1);
            end
         end
      end
   endtask

   task automatic test_skip_first();
      q_bits.delete();
      for (int j = 0; j < NB; j++) push_byte(8'h00);
      run_frame(1'b1, 1'b1);
      model_frame(1'b1);
      total++;
      if (frameData !== 24'h000000 || frameValid !== 1'b1) begin
         bad++; $display("FAIL skip_first: got %h v=%b required 000000 v=1", frameData, frameValid);
      end
   endtask

   task automatic test_reset_midframe();
      q_bits.delete();
      @(negedge masterClk); active = 1'b1;
      repeat (2) @(negedge masterClk);
      send_bit(1'b0, -1);
      for (int i = 0; i < 10; i++) send_bit(1'($urandom), -1);
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL reset_pre_busy: got %b required 1", busy);
      end
      @(negedge masterClk); nReset = 1'b0; active = 1'b0; bitClk = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge masterClk);
         total++;
         if ({frameData, frameValid, fwdEn, busy, errCnt} !== '0) begin
            bad++; $display("FAIL reset_mid[%0d]: got data=%h v=%b f=%b b=%b e=%0d required all 0",
                            c, frameData, frameValid, fwdEn, busy, errCnt);
         end
      end
      nReset = 1'b1;
      m_data = '0; m_valid = 1'b0; m_err = 0;
      @(negedge masterClk);
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         int  n;
         bit  ack;
         q_bits.delete();
         n = ($urandom_range(0, 9) < 7) ? DW + 8 * $urandom_range(0, 3)
                                         : $urandom_range(0, DW - 1);
         for (int i = 0; i < n; i++) q_bits.push_back(1'($urandom));
         ack = 1'($urandom);
         run_frame(1'($urandom), ack);
         model_frame(ack);
         total++;
         if (frameData !== m_data || frameValid !== m_valid || errCnt !== 8'(m_err) ||
             busy !== 1'b0 || fwdEn !== 1'b0) begin
            bad++; $display("FAIL random[%0d] n=%0d: got data=%h v=%b err=%0d b=%b f=%b required data=%h v=%b err=%0d b=0 f=0",
                            k, n, frameData, frameValid, errCnt, busy, fwdEn, m_data, m_valid, m_err);
         end
         total++;
         if (obs_fwd !== exp_fwd_vec() || obs_busy_c !== (n >= DW) || obs_fwd_end !== 1'b0) begin
            bad++; $display("FAIL random_fwd[%0d] n=%0d: got fwd=%h busy_c=%b fend=%b required fwd=%h busy_c=%b fend=0",
                            k, n, obs_fwd, obs_busy_c, obs_fwd_end, exp_fwd_vec(), n >= DW);
         end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 300; k++) begin
         q_bits.delete();
         for (int i = $urandom_range(0, 6); i > 0; i--) q_bits.push_back(1'($urandom));
         run_frame(1'($urandom), 1'b0);
         model_frame(1'b0);
      end
      total++;
      if (errCnt !== 8'hFF || frameData !== m_data) begin
         bad++; $display("FAIL saturation: got err=%h data=%h required err=ff data=%h",
                         errCnt, frameData, m_data);
      end
   endtask

   initial begin
      test_reset_initial();
      test_basic();
      test_ack_clear();
      test_short();
      test_back_to_back();
      test_skip_first();
      test_reset_midframe();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
